// File: rtl/histogram_controller_if.sv
// Sample-in and result-out handshake bundle
// for the histogram readout controller.
interface histogram_controller_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_bin;
  logic [15:0] out_count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bin,
    output out_count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bin,
    input  out_count
  );
endinterface

// File: rtl/histogram_controller.sv
// Distributes samples over four histogram lanes,
// then reads back the summed bins and clears lanes.
module histogram_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_end,
  histogram_controller_if.slave hist,
  output logic [3:0]  lane_enable,
  output logic [7:0]  lane_data,
  output logic [2:0]  lane_addr,
  output logic        lane_clear,
  input  logic [13:0] lane_hist0,
  input  logic [13:0] lane_hist1,
  input  logic [13:0] lane_hist2,
  input  logic [13:0] lane_hist3,
  output logic        busy
);

  typedef enum logic [2:0] {
    ACCEPT,
    DRAIN,
    ADDR,
    WAIT,
    OUTPUT,
    CLEAR
  } state_t;

  state_t      state;
  logic [1:0]  ptr;
  logic [2:0]  bin;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [2:0]  out_bin_q;
  logic [15:0] out_count_q;
  logic [15:0] sum;
  logic        accept;

  assign sum = 16'(lane_hist0)
             + 16'(lane_hist1)
             + 16'(lane_hist2)
             + 16'(lane_hist3);

  assign accept = hist.in_valid & in_ready_q;

  assign hist.in_ready  = in_ready_q;
  assign hist.out_valid = out_valid_q;
  assign hist.out_bin   = out_bin_q;
  assign hist.out_count = out_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ACCEPT;
      ptr         <= '0;
      bin         <= '0;
      lane_enable <= '0;
      lane_data   <= '0;
      lane_addr   <= '0;
      lane_clear  <= 1'b1;
      in_ready_q  <= 1'b0;
      busy        <= 1'b0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_count_q <= '0;
    end else begin
      lane_enable <= '0;
      unique case (state)
        ACCEPT: begin
          lane_clear <= 1'b0;
          if (accept) begin
            lane_enable <= 4'b0001 << ptr;
            lane_data   <= hist.in_data;
            ptr         <= ptr + 2'd1;
          end
          // in_ready_q is low only in the
          // first cycle out of reset
          if (frame_end && in_ready_q) begin
            state      <= DRAIN;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        DRAIN: begin
          bin   <= '0;
          state <= ADDR;
        end
        ADDR: begin
          lane_addr <= bin;
          state     <= WAIT;
        end
        WAIT: begin
          out_count_q <= sum;
          out_bin_q   <= bin;
          out_valid_q <= 1'b1;
          state       <= OUTPUT;
        end
        OUTPUT: begin
          if (hist.out_ready) begin
            out_valid_q <= 1'b0;
            if (bin == 3'd7) begin
              state      <= CLEAR;
              lane_clear <= 1'b1;
            end else begin
              bin   <= bin + 3'd1;
              state <= ADDR;
            end
          end
        end
        CLEAR: begin
          lane_clear <= 1'b0;
          ptr        <= '0;
          bin        <= '0;
          in_ready_q <= 1'b1;
          busy       <= 1'b0;
          state      <= ACCEPT;
        end
        default: begin
          state <= ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_controller.sv
// Random and directed frames against a four-lane
// histogram environment and a per-bin count model.
module tb_histogram_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_end;
  logic [3:0]  lane_enable;
  logic [7:0]  lane_data;
  logic [2:0]  lane_addr;
  logic        lane_clear;
  logic [13:0] lane_hist0;
  logic [13:0] lane_hist1;
  logic [13:0] lane_hist2;
  logic [13:0] lane_hist3;
  logic        busy;

  histogram_controller_if hif ();

  histogram_controller dut (
    .clock       (clock),
    .reset       (reset),
    .frame_end   (frame_end),
    .hist        (hif),
    .lane_enable (lane_enable),
    .lane_data   (lane_data),
    .lane_addr   (lane_addr),
    .lane_clear  (lane_clear),
    .lane_hist0  (lane_hist0),
    .lane_hist1  (lane_hist1),
    .lane_hist2  (lane_hist2),
    .lane_hist3  (lane_hist3),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // lane environment: bin = top 3 bits of sample
  logic [13:0] mem [4][8];

  always @(posedge clock) begin
    for (int l = 0; l < 4; l++)
      for (int b = 0; b < 8; b++)
        if (lane_clear)
          mem[l][b] <= '0;
        else if (lane_enable[l] &&
                 lane_data[7:5] == 3'(b))
          mem[l][b] <= mem[l][b] + 14'd1;
  end

  assign lane_hist0 = mem[0][lane_addr];
  assign lane_hist1 = mem[1][lane_addr];
  assign lane_hist2 = mem[2][lane_addr];
  assign lane_hist3 = mem[3][lane_addr];

  int n_cmp = 0;
  int n_bad = 0;
  int exp_hist [8];
  int nacc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    nacc = 0;
    for (int b = 0; b < 8; b++) exp_hist[b] = 0;
  endtask

  task automatic step();
    logic       acc;
    logic       rst;
    logic [7:0] d;
    rst = reset;
    acc = hif.in_valid && hif.in_ready && !rst;
    d   = hif.in_data;
    @(posedge clock);
    @(negedge clock);
    if (acc) begin
      exp_hist[d[7:5]]++;
      chk("lane_enable", 32'(lane_enable),
          32'(1 << (nacc % 4)));
      chk("lane_data", 32'(lane_data), 32'(d));
      nacc++;
    end else if (!rst) begin
      chk("lane_enable_idle",
          32'(lane_enable), 0);
    end
  endtask

  task automatic chk_reset();
    chk("rst_lane_enable", 32'(lane_enable), 0);
    chk("rst_lane_data", 32'(lane_data), 0);
    chk("rst_lane_addr", 32'(lane_addr), 0);
    chk("rst_lane_clear", 32'(lane_clear), 1);
    chk("rst_out_valid", 32'(hif.out_valid), 0);
    chk("rst_out_bin", 32'(hif.out_bin), 0);
    chk("rst_out_count", 32'(hif.out_count), 0);
    chk("rst_in_ready", 32'(hif.in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  task automatic end_frame(input logic v,
                           input logic [7:0] d);
    hif.in_valid = v;
    hif.in_data  = d;
    frame_end    = 1'b1;
    step();
    frame_end    = 1'b0;
    hif.in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    hif.in_valid = 1'b1;
    hif.in_data  = d;
    step();
    hif.in_valid = 1'b0;
  endtask

  task automatic rand_samples(input int n);
    for (int i = 0; i < n; i++) begin
      hif.in_valid = 1'($urandom_range(0, 1));
      hif.in_data  = 8'($urandom);
      step();
    end
    hif.in_valid = 1'b0;
  endtask

  // mode 0: ready high, 1: random ready,
  // 2: ten-cycle stall on bin 3
  // iv 0: in_valid low, 1: high, 2: random
  task automatic readout(input int mode,
                         input int iv,
                         output int busy_cyc);
    int         nbin;
    int         clears;
    int         since;
    int         stall;
    logic       stalled;
    logic       rdy;
    logic [2:0] pb;
    logic [15:0] pc;
    nbin = 0; clears = 0; since = 0;
    stall = 0; stalled = 0; busy_cyc = 0;
    pb = '0; pc = '0;
    for (int c = 0; c < 400; c++) begin
      since++;
      if (!busy && nbin == 8) break;
      if (busy) busy_cyc++;
      if (lane_clear) clears++;
      chk("in_ready_vs_busy",
          32'(hif.in_ready), 32'(!busy));
      if (stalled) begin
        chk("hold_valid", 32'(hif.out_valid), 1);
        chk("hold_bin", 32'(hif.out_bin), 32'(pb));
        chk("hold_count",
            32'(hif.out_count), 32'(pc));
      end else if (hif.out_valid && nbin > 0) begin
        chk("latency", since, 3);
      end
      unique case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          rdy = 1'b1;
          if (hif.out_valid && hif.out_bin == 3'd3
              && stall < 10) begin
            rdy = 1'b0;
            stall++;
          end
        end
      endcase
      hif.out_ready = rdy;
      stalled = hif.out_valid && !rdy;
      pb = hif.out_bin;
      pc = hif.out_count;
      if (hif.out_valid && rdy) begin
        chk("out_bin", 32'(hif.out_bin), nbin);
        chk("out_count", 32'(hif.out_count),
            (nbin < 8) ? exp_hist[nbin] : -1);
        nbin++;
        since = 0;
      end
      hif.in_valid = (iv == 2) ?
        1'($urandom_range(0, 1)) : 1'(iv);
      hif.in_data  = 8'($urandom);
      step();
    end
    hif.in_valid  = 1'b0;
    hif.out_ready = 1'b1;
    chk("bins_emitted", nbin, 8);
    chk("clear_pulses", clears, 1);
    if (mode == 2) chk("stall_len", stall, 10);
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int ov;
    logic found;
    logic [7:0] s37 [8];
    s37 = '{8'd0, 8'd40, 8'd70, 8'd100,
            8'd130, 8'd170, 8'd200, 8'd250};
    reset         = 1'b1;
    frame_end     = 1'b0;
    hif.in_valid  = 1'b0;
    hif.in_data   = '0;
    hif.out_ready = 1'b1;
    model_clear();
    @(negedge clock);
    step(); step(); step();
    chk_reset();
    reset = 1'b0;
    step();
    chk("post_rst_clear", 32'(lane_clear), 0);
    chk("post_rst_ready", 32'(hif.in_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);

    for (int i = 0; i < 8; i++) send(s37[i]);
    end_frame(1'b0, 8'd0);
    readout(0, 0, bc);
    chk("busy_cycles_full", bc, 26);

    end_frame(1'b1, 8'd5);
    readout(0, 0, bc);

    end_frame(1'b0, 8'd0);
    readout(0, 0, bc);
    chk("busy_cycles_empty", bc, 26);

    for (int f = 0; f < 3; f++) begin
      rand_samples(int'($urandom_range(5, 40)));
      end_frame(1'($urandom_range(0, 1)),
                8'($urandom));
      readout(1, 2, bc);
    end

    rand_samples(20);
    end_frame(1'b0, 8'd0);
    readout(2, 0, bc);

    rand_samples(12);
    end_frame(1'b1, 8'($urandom));
    readout(0, 1, bc);
    chk("busy_cycles_iv", bc, 26);

    rand_samples(30);
    end_frame(1'b0, 8'd0);
    found = 1'b0;
    hif.out_ready = 1'b1;
    for (int c = 0; c < 200 && !found; c++) begin
      found = hif.out_valid &&
              hif.out_bin == 3'd4;
      step();
    end
    chk("reach_bin4", 32'(found), 1);
    step();
    step();
    reset = 1'b1;
    step();
    chk_reset();
    reset = 1'b0;
    model_clear();
    ov = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (hif.out_valid) ov++;
    end
    chk("no_valid_after_abort", ov, 0);
    end_frame(1'b0, 8'd0);
    readout(0, 0, bc);
    chk("busy_cycles_after_rst", bc, 26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
